// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS32 multicycle main-control FSM: states, opcodes,
// select codes and the decoded control bundle.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTE  = 4'd6;
    localparam state_t S_ALUWB    = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_ADDIEXEC = 4'd9;
    localparam state_t S_ADDIWB   = 4'd10;
    localparam state_t S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure Moore decode from FSM state to raw datapath controls; the top applies
// the mem_ready and reset qualification.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                ctrl.alu_src_b = SRCB_IMMSH2;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle main-control FSM for the MIPS32 core; sequences fetch through
// writeback and waits on mem_ready in the memory-facing states.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   rdy;
    logic   in_fetch;
    logic   en;

    assign rdy      = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign in_fetch = (state_q == S_FETCH);
    assign en       = ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
                else if (opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (opcode == OP_ADDI)             state_d = S_ADDIEXEC;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else                                    state_d = S_FETCH;
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;

    // Enables are gated by reset so an abort mid-access never leaves a partial write.
    assign mem_read   = en & ctrl.mem_read;
    assign mem_write  = en & ctrl.mem_write;
    assign ir_write   = en & ctrl.ir_write & rdy;
    assign pc_write   = en & ctrl.pc_write & (rdy | ~in_fetch);
    assign branch     = en & ctrl.branch;
    assign reg_write  = en & ctrl.reg_write;
    assign illegal_op = en & (state_q == S_DECODE) & ~op_known(opcode);
    assign state_dbg  = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle main-control FSM for the MIPS32 core. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives all datapath selects and write enables, plus the 2-bit alu_op consumed by alu_control. Memory accesses wait on a ready handshake, so the core tolerates variable-latency memory.

Parameters:
MEM_WAIT_EN, 1, 1: mem_ready gates memory states; 0: mem_ready ignored and treated as 1.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high
opcode  input  6  instr[31:26] from instruction register; stable from DECODE until next FETCH
mem_ready  input  1  memory completes current read/write this cycle
alu_op  output  2  00 ADD, 01 SUB, 10 use funct (to alu_control)
alu_src_a  output  1  0 PC, 1 regA
alu_src_b  output  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  output  1  0 PC address, 1 ALUOut address
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  load instruction register
pc_write  output  1  unconditional PC load
branch  output  1  PC load if ALU zero
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 memory data
reg_write  output  1  register-file write
illegal_op  output  1  one-cycle pulse on unknown opcode
state_dbg  output  4  current state encoding

Behaviour:
- Moore FSM with a registered state; outputs decoded from state. ir_write, pc_write in FETCH and mem_read/mem_write in MEMREAD/MEMWRITE are additionally qualified as below.
- Reset: state = FETCH. While reset is high, every enable (mem_read, mem_write, ir_write, pc_write, branch, reg_write, illegal_op) is forced 0. Selects hold their FETCH values: all 0 except alu_src_b=01.
- Unlisted outputs are 0 in every state.
- FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Stay while !mem_ready, else go to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - other -> FETCH with illegal_op=1 this cycle only
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD (3): iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB (4): reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWRITE (5): iord=1, mem_write=1, held high for all wait cycles. On mem_ready -> FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB (7): reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
- ADDIEXEC (9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.
- ADDIWB (10): reg_dst=0, reg_write=1 -> FETCH.
- JUMP (11): pc_src=10, pc_write=1 -> FETCH.
- Undefined state encodings (12-15) -> FETCH next cycle with all enables 0.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
  - illegal opcode: 2 cycles
  - Each mem_ready=0 cycle adds one cycle.
- Reset asserted mid-operation: state goes immediately to FETCH and enables drop the same cycle, with no partial writes. The first fetch request comes the cycle after reset deasserts.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.

Decomposition:
- Package mips_ctrl_pkg:
  - state enum (4-bit, encodings above)
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - alu_op localparams ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alu_src_b and pc_src select localparams
- Optional sub-module mips_ctrl_outdec: pure state-to-output decode; FSM next-state logic stays in the top.

Test Plan:
- Reset held, then released with opcode=100011 and mem_ready 0,0,1 in FETCH:
  - during reset all enables are 0
  - ir_write/pc_write pulse only on the third FETCH cycle
  - sequence then runs DECODE, MEMADR, MEMREAD (mem_ready=1), MEMWB with reg_write=1, mem_to_reg=1, reg_dst=0.
- opcode=000000, mem_ready=1: EXECUTE shows alu_op=10, alu_src_a=1, alu_src_b=00; ALUWB shows reg_dst=1, reg_write=1; back in FETCH after 4 cycles.
- opcode=000100: DECODE shows alu_src_b=11; BRANCH shows alu_op=01, pc_src=01, branch=1, pc_write=0; 3-cycle total.
- opcode=101011, mem_ready=0 for 3 cycles in MEMWRITE: mem_write=1 and iord=1 held 4 cycles, reg_write never asserted, then FETCH.
- opcode=000010 -> JUMP with pc_src=10, pc_write=1. opcode=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH.
- Reset asserted in MEMWRITE: mem_write drops the same cycle, state_dbg=0, and no further writes occur until a new FETCH completes.
